// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity modes
// and a constant sizing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchroniser for an idle-high asynchronous input; resets to 1
// so a line held in reset never looks like a start bit.
module uart_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with false-start rejection, parity,
// framing and break detection, and a valid/ready output with overrun pulse.
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_EN   = 1,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    import uart_pkg::*;

    localparam int TW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic w_rxs;

    uart_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rxs)
    );

    rx_state_t            r_state, w_state_nx;
    logic [TW-1:0]        r_tick,  w_tick_nx;
    logic [BW-1:0]        r_bit,   w_bit_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_par,   w_par_nx;
    logic                 r_podd,  w_podd_nx;
    logic                 r_ferr,  w_ferr_nx;
    logic                 r_done,  w_done_nx;
    logic                 r_brk,   w_brk_nx;
    logic                 w_mid, w_end, w_perr;

    assign w_mid = (r_tick == TICK_MID);
    assign w_end = (r_tick == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_podd  <= 1'b0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tick  <= w_tick_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_podd  <= w_podd_nx;
            r_ferr  <= w_ferr_nx;
            r_done  <= w_done_nx;
            r_brk   <= w_brk_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = r_tick;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_podd_nx  = r_podd;
        w_ferr_nx  = r_ferr;
        w_done_nx  = 1'b0;
        w_brk_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nx = START;
                    w_tick_nx  = '0;
                end
            end
            START: begin
                if (b_tick) begin
                    if (!w_mid) begin
                        w_tick_nx = r_tick + TW'(1);
                    end else if (w_rxs) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = DATA;
                        w_tick_nx  = '0;
                        w_bit_nx   = '0;
                        w_podd_nx  = (parity_odd == PAR_ODD);
                        w_ferr_nx  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (!w_end) begin
                        w_tick_nx = r_tick + TW'(1);
                    end else begin
                        w_tick_nx  = '0;
                        w_shift_nx = {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit == DATA_LAST) begin
                            w_bit_nx   = '0;
                            w_state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            w_bit_nx = r_bit + BW'(1);
                        end
                    end
                end
            end
            PARITY: begin
                if (b_tick) begin
                    if (!w_end) begin
                        w_tick_nx = r_tick + TW'(1);
                    end else begin
                        w_tick_nx  = '0;
                        w_par_nx   = w_rxs;
                        w_state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (b_tick) begin
                    if (!w_end) begin
                        w_tick_nx = r_tick + TW'(1);
                    end else begin
                        w_tick_nx = '0;
                        // An all-zero frame through the first stop bit is a break, not a word.
                        if (r_bit == '0 && !w_rxs && r_shift == '0 &&
                            (PARITY_EN == 0 || !r_par)) begin
                            w_brk_nx   = 1'b1;
                            w_bit_nx   = '0;
                            w_state_nx = BRK_WAIT;
                        end else begin
                            if (!w_rxs) w_ferr_nx = 1'b1;
                            if (r_bit == STOP_LAST) begin
                                w_bit_nx   = '0;
                                w_done_nx  = 1'b1;
                                w_state_nx = IDLE;
                            end else begin
                                w_bit_nx = r_bit + BW'(1);
                            end
                        end
                    end
                end
            end
            BRK_WAIT: begin
                if (w_rxs) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_perr = (PARITY_EN != 0) ? (^r_shift ^ r_par ^ r_podd) : 1'b0;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_perr_o, r_ferr_o, r_ovr;

    // Holding register: a completed word only replaces one that is leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_done) begin
                if (!r_valid || rx_ready) begin
                    r_data   <= r_shift;
                    r_perr_o <= w_perr;
                    r_ferr_o <= r_ferr;
                    r_valid  <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_o;
    assign frame_err  = r_ferr_o;
    assign overrun    = r_ovr;
    assign break_det  = r_brk;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg at default parameters: table of frames
// plus hand-written sequences for hold, overrun, glitch, break and reset.
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun, break_det;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int ovr_cyc = 0;
    int brk_cnt = 0;
    int last_start = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       podd;
        logic       perr;
        logic       ferr;
    } vec_t;

    exp_t sb[$];
    vec_t vt[11];

    uart_rx_cfg dut (
        .clk        (clk),
        .rst        (rst),
        .b_tick     (b_tick),
        .rx         (rx),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .break_det  (break_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) b_tick = (cyc % 4 == 3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (break_det) brk_cnt++;
        if (!rst && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got 0x%0h with no word expected", rx_data);
            end else begin
                e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
            end
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic align();
        do @(negedge clk); while (cyc % 4 != 0);
        last_start = cyc;
    endtask

    // Low stop bits are held for only 3/4 of a bit so the line is high again
    // before the receiver could mistake the tail for a new start bit.
    task automatic send_body(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        if (stop) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (16) @(negedge clk);
        end
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic podd);
        parity_odd = podd;
        align();
        send_body(d, par, stop);
    endtask

    task automatic push(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic ready_pulse();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, bb, k, target;

        vt = '{
            '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}
        };

        // Reset state, with b_tick running
        repeat (4) @(posedge clk);
        settle();
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_break_det", 32'(break_det), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Word held until the consumer takes it
        rx_ready = 1'b0;
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        settle();
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_data", 32'(rx_data), 32'hA5);
        ready_pulse();
        settle();
        check("valid_clears_after_ready", 32'(rx_valid), 32'd0);
        check("hold_popped", 32'(sb.size()), 32'd0);

        // Table of frames, consumer always ready
        rx_ready = 1'b1;
        foreach (vt[i]) begin
            push(vt[i].data, vt[i].perr, vt[i].ferr);
            send_frame(vt[i].data, vt[i].par, vt[i].stop, vt[i].podd);
            drain();
        end

        // Short low glitch is rejected, next frame still clean
        align();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        settle();
        check("glitch_no_valid", 32'(rx_valid), 32'd0);
        push(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        drain();

        // Overrun: second word dropped while the first is held
        rx_ready = 1'b0;
        ob = ovr_cnt;
        push(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        k = ovr_cyc - last_start;
        settle();
        check("overrun_pulses", 32'(ovr_cnt - ob), 32'd1);
        check("overrun_keeps_old", 32'(rx_data), 32'h3C);
        check("overrun_still_valid", 32'(rx_valid), 32'd1);
        ready_pulse();
        settle();
        check("overrun_old_popped", 32'(sb.size()), 32'd0);
        if (k <= 1 || k > 2000) k = 2;

        // Same pair, ready raised exactly for the completion cycle of the second word
        ob = ovr_cnt;
        push(8'h3C, 1'b0, 1'b0);
        push(8'hC3, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        align();
        target = last_start + k - 1;
        fork
            send_body(8'hC3, 1'b0, 1'b1);
            begin
                while (cyc < target) begin
                    @(posedge clk);
                    #1;
                end
                rx_ready = 1'b1;
            end
        join
        drain();
        check("coincident_no_overrun", 32'(ovr_cnt - ob), 32'd0);

        // Break: line low for 12 bit periods
        rx_ready = 1'b1;
        bb = brk_cnt;
        align();
        rx = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        settle();
        check("break_pulses", 32'(brk_cnt - bb), 32'd1);
        check("break_no_valid", 32'(rx_valid), 32'd0);
        push(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset in the middle of a data bit clears a held word and the frame
        rx_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        settle();
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        check("pre_rst_perr", 32'(parity_err), 32'd1);
        align();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_perr", 32'(parity_err), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        rx_ready = 1'b1;
        push(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and next-generation serial RX for the peripheral subsystem. Generic data width, oversampling ratio, parity and stop-bit count. Adds false-start rejection, per-word parity/framing error flags, break detection, and a valid/ready output handshake with overrun reporting. Driven by the shared baud generator tick; feeds the UART register block or RX FIFO.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, b_tick pulses per bit period, even, >=4
PARITY_EN, 1, 1 = one parity bit follows data; 0 = none
STOP_BITS, 1, stop bits checked, 1 or 2
SYNC_STAGES, 2, rx synchroniser flops, >=2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
b_tick  in  1  one-clk oversample strobe
rx  in  1  asynchronous serial line, idle high
parity_odd  in  1  0 = even, 1 = odd; sampled at start-bit midpoint
rx_data  out  DATA_BITS  received word, stable while rx_valid
rx_valid  out  1  word available
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
parity_err  out  1  parity mismatch for held word, qualified by rx_valid
frame_err  out  1  stop bit low for held word, qualified by rx_valid
overrun  out  1  one-clk pulse: completed word dropped
break_det  out  1  one-clk pulse: break condition detected

Behaviour:
- Reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, break_det=0. Synchroniser flops=1, FSM=IDLE, counters=0. Reset mid-frame discards the frame.
- rx passes through SYNC_STAGES flops. All decisions use the synchronised value (rxs).
- tick_cnt counts b_tick, width clog2(OVERSAMPLE). bit_cnt counts data bits, width clog2(DATA_BITS+1).
- IDLE: rxs=0 -> START, tick_cnt=0.
- START: at tick_cnt==OVERSAMPLE/2-1 (bit midpoint):
  - rxs=1 -> IDLE (glitch rejected, no output).
  - else -> DATA, tick_cnt=0, bit_cnt=0, latch parity_odd.
- DATA: sample rxs on the b_tick where tick_cnt==OVERSAMPLE-1, shift in LSB first, tick_cnt wraps to 0. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: sample once. perr = XOR(data, parity bit) XOR latched parity_odd.
- STOP: sample STOP_BITS times.
  - Any sampled 0 -> ferr=1.
  - Exit to IDLE on the last sample. Early 0 in a 2-stop frame is still counted out.
- Break: all data bits 0, parity bit 0 (if present), and first stop bit 0 -> break_det pulse, word not delivered, FSM -> BRK_WAIT. BRK_WAIT stays until rxs=1, then -> IDLE.
- Delivery, one clk after the final stop sample tick:
  - If rx_valid=0, or rx_valid & rx_ready in that same cycle: load rx_data, parity_err, frame_err; rx_valid=1.
  - Else keep old word and flags, pulse overrun, drop new word.
- rx_valid clears the cycle after valid & ready unless a new word loads at the same edge. A new word has priority; rx_valid stays 1.
- Non-break frames with framing error are delivered with frame_err=1.
- b_tick while rst=1 is ignored.

Decomposition:
- Package uart_pkg holds:
  - FSM encoding: IDLE, START, DATA, PARITY, STOP, BRK_WAIT (3 bits).
  - Parity mode constants PAR_EVEN=0, PAR_ODD=1.
  - Helper function clog2.
- Sub-module uart_bit_sync: parametrised SYNC_STAGES flop chain with reset value 1, reusable by the TX CTS input.

Test Plan:
- Defaults, even parity, send 0xA5 with parity 0 and stop 1 -> rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0; held until rx_ready pulse, then rx_valid=0 next clk.
- Send 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1. Repeat with parity_odd=1 -> parity_err=0.
- rx low for 5 ticks then high -> no rx_valid, FSM back in IDLE; following clean 0x3C frame received correctly.
- 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1, break_det=0.
- rx_ready=0, send 0x3C then 0xC3 -> rx_data stays 0x3C, one overrun pulse at 0xC3 completion. Repeat with rx_ready=1 coincident with completion -> 0xC3 loaded, no overrun.
- rx low for 12 bit periods -> exactly one break_det pulse, no rx_valid. After rx high, 0x55 received normally.
- rst asserted mid-DATA -> all outputs 0 next clk; subsequent 0x81 frame received correctly.
